piso4_tx: RTL and testbench

PISO4_TX -- requirements
Module: piso4_tx

---
 rtl/piso4_tx.sv | 102 ++++++++++
 tb/tb_piso4_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/piso4_tx.sv
// Parallel-in serial-out transmitter: one-word holding buffer feeding an LSB-first shifter.
// Words queued behind the active one are chained without an idle bit between them.
//
// state | meaning
// IDLE  | nothing shifting; dout parked at IDLE_LEVEL, a buffered word starts next edge
// SHIFT | sr[0] is on dout, advancing one bit per tick-qualified edge
module piso4_tx #(
    parameter int   WIDTH      = 4,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    input  logic             tick,
    output logic             dout,
    output logic             frame,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] buffer, buffer_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             hv, hv_nxt;
    logic             done_nxt;

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state  <= IDLE;
            buffer <= '0;
            sr     <= '0;
            cnt    <= '0;
            hv     <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            buffer <= buffer_nxt;
            sr     <= sr_nxt;
            cnt    <= cnt_nxt;
            hv     <= hv_nxt;
            done   <= done_nxt;
        end
    end

    // Capture and drain never collide: capture needs hv=0, draining needs hv=1.
    always_comb begin
        state_nxt  = state;
        buffer_nxt = buffer;
        sr_nxt     = sr;
        cnt_nxt    = cnt;
        hv_nxt     = hv;
        done_nxt   = 1'b0;

        if (load && !hv) begin
            buffer_nxt = din;
            hv_nxt     = 1'b1;
        end

        case (state)
            IDLE: begin
                if (hv) begin
                    sr_nxt    = buffer;
                    cnt_nxt   = '0;
                    hv_nxt    = 1'b0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (cnt != LAST) begin
                        sr_nxt  = {1'b0, sr[WIDTH-1:1]};
                        cnt_nxt = cnt + CW'(1);
                    end else begin
                        done_nxt = 1'b1;
                        cnt_nxt  = '0;
                        if (hv) begin
                            sr_nxt = buffer;
                            hv_nxt = 1'b0;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = !hv;
    assign frame = (state == SHIFT);
    assign busy  = (state == SHIFT) | hv;
    assign dout  = (state == SHIFT) ? sr[0] : IDLE_LEVEL;

endmodule

// File: tb/tb_piso4_tx.sv
// Bench for piso4_tx: stimulus queues expected serial bits, a negedge monitor
// pops one per tick-qualified bit while frame is high and compares dout.
module tb_piso4_tx;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] din = '0;
    logic       load = 1'b0;
    logic       tick = 1'b0;
    logic       ready, dout, frame, busy, done;

    logic       load1 = 1'b0;
    logic       ready1, dout1, frame1, busy1, done1;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    logic exp_q[$];

    piso4_tx #(.WIDTH(4), .IDLE_LEVEL(1'b0)) u_dut (
        .clk(clk), .clear(clear), .din(din), .load(load), .ready(ready),
        .tick(tick), .dout(dout), .frame(frame), .busy(busy), .done(done)
    );

    piso4_tx #(.WIDTH(4), .IDLE_LEVEL(1'b1)) u_dut1 (
        .clk(clk), .clear(clear), .din(din), .load(load1), .ready(ready1),
        .tick(tick), .dout(dout1), .frame(frame1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_word(input logic [3:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) exp_q.push_back(w[i]);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", busy, 1'b0);
    endtask

    always @(negedge clk) begin
        if (clear) begin
            if (done) done_seen++;
            if (frame && tick) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: got %0b expected none at %0t", dout, $time);
                end else begin
                    check("serial_bit", dout, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        #2;
        check("rst_ready", ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_frame", frame, 1'b0);
        check("rst_dout", dout, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dout_idle1", dout1, 1'b1);

        // single word, tick tied high; first edge after release accepts
        @(posedge clk); #1;
        clear = 1'b1;
        tick  = 1'b1;
        din   = 4'b1011;
        load  = 1'b1;
        push_word(4'b1011, 4);
        @(posedge clk); #1;
        load = 1'b0;
        check("accept_ready", ready, 1'b0);
        check("accept_frame", frame, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            check("w1_frame", frame, (k <= 4));
            check("w1_done", done, (k == 5));
            if (k == 1) check("w1_latency_dout", dout, 1'b1);
        end
        check("w1_ready", ready, 1'b1);
        check("w1_busy", busy, 1'b0);

        // tick every third cycle, each bit held three cycles
        tick = 1'b0;
        din  = 4'b0110;
        load = 1'b1;
        push_word(4'b0110, 4);
        @(posedge clk); #1;
        load = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
            if (k <= 12) begin
                logic [3:0] w;
                w = 4'b0110;
                check("w2_frame", frame, 1'b1);
                check("w2_hold", dout, w[(k - 1) / 3]);
            end else begin
                check("w2_frame_end", frame, 1'b0);
                check("w2_done", done, 1'b1);
            end
            tick = (k % 3 == 0) && (k < 13);
        end
        @(posedge clk); #1;

        // back-to-back words, third load ignored while buffer full
        tick = 1'b1;
        din  = 4'hA;
        load = 1'b1;
        push_word(4'hA, 4);
        @(posedge clk); #1;
        load = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            check("b2b_frame", frame, (k <= 8));
            check("b2b_done", done, (k == 5 || k == 9));
            if (k == 1) begin
                check("b2b_ready_free", ready, 1'b1);
                din  = 4'h5;
                load = 1'b1;
                push_word(4'h5, 4);
            end else if (k == 2) begin
                check("b2b_ready_full", ready, 1'b0);
                din  = 4'hF;
                load = 1'b1;
            end else if (k == 4) begin
                load = 1'b0;
            end
        end
        check("b2b_idle", busy, 1'b0);

        // clear during bit 2 of 4'hF, with 4'h9 waiting in the buffer
        din  = 4'hF;
        load = 1'b1;
        push_word(4'hF, 2);
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #1;
        din  = 4'h9;
        load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        check("abort_hv", ready, 1'b0);
        @(posedge clk); #1;
        clear = 1'b0;
        #1;
        check("abort_ready", ready, 1'b1);
        check("abort_busy", busy, 1'b0);
        check("abort_frame", frame, 1'b0);
        check("abort_dout", dout, 1'b0);
        check("abort_done", done, 1'b0);
        @(posedge clk); #1;
        clear = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("post_abort_busy", busy, 1'b0);
            check("post_abort_done", done, 1'b0);
        end
        din  = 4'h3;
        load = 1'b1;
        push_word(4'h3, 4);
        @(posedge clk); #1;
        load = 1'b0;
        @(posedge clk); #1;
        check("w3_latency_frame", frame, 1'b1);
        check("w3_latency_dout", dout, 1'b1);
        wait_idle();
        @(posedge clk); #1;

        // IDLE_LEVEL=1 instance never loaded; tick toggling must not matter
        for (int k = 0; k < 6; k++) begin
            tick = ~tick;
            @(posedge clk); #1;
            check("idle1_dout", dout1, 1'b1);
            check("idle1_frame", frame1, 1'b0);
            check("idle1_busy", busy1, 1'b0);
        end
        check("idle1_ready", ready1, 1'b1);

        check("queue_drained", exp_q.size(), 0);
        check("done_pulses", done_seen, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
